// File: rtl/pipestage_elastic.sv
// Chain of p_depth full-throughput skid-buffer stages with registered ready/valid on both sides.
// Optional occupancy counter output o_count is built when PIPESTAGE_COUNT_EN is defined.
module pipestage_elastic #(
  parameter int p_width = 32,
  parameter int p_depth = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [p_width-1:0] in,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [p_width-1:0] out
`ifdef PIPESTAGE_COUNT_EN
  ,
  output logic [$clog2(2*p_depth+1)-1:0] o_count
`endif
);

  // Handshake: a word moves across a boundary only at a posedge where the
  // sender's valid and the receiver's ready are both 1. Ready of every stage is
  // !skid_valid, so it is a flop output and never depends on the downstream side.

  logic [p_depth-1:0] main_v;
  logic [p_depth-1:0] skid_v;
  logic [p_width-1:0] main_d [p_depth];

  logic [p_depth-1:0] up_v;
  logic [p_width-1:0] up_d [p_depth];
  logic [p_depth-1:0] dn_r;

  for (genvar k = 0; k < p_depth; k++) begin : g_stage
    logic               mv;
    logic               sv;
    logic [p_width-1:0] md;
    logic [p_width-1:0] sd;
    logic               up_xfer;
    logic               dn_xfer;

    if (k == 0) begin : g_first
      assign up_v[k] = i_valid;
      assign up_d[k] = in;
    end else begin : g_inner
      assign up_v[k] = main_v[k-1];
      assign up_d[k] = main_d[k-1];
    end

    if (k == p_depth - 1) begin : g_last
      assign dn_r[k] = i_ready;
    end else begin : g_mid
      assign dn_r[k] = !skid_v[k+1];
    end

    assign up_xfer = up_v[k] && !sv;
    assign dn_xfer = mv && dn_r[k];

    // Main refills from skid first so order is preserved; the skid only ever
    // captures while main is held, so skid full implies main full.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        mv <= 1'b0;
        sv <= 1'b0;
        md <= '0;
        sd <= '0;
      end else if (!mv || dn_xfer) begin
        if (sv) begin
          mv <= 1'b1;
          md <= sd;
          sv <= 1'b0;
        end else begin
          mv <= up_xfer;
          if (up_xfer) md <= up_d[k];
        end
      end else if (up_xfer) begin
        sv <= 1'b1;
        sd <= up_d[k];
      end
    end

    assign main_v[k] = mv;
    assign skid_v[k] = sv;
    assign main_d[k] = md;
  end

  assign o_ready = !skid_v[0];
  assign o_valid = main_v[p_depth-1];
  assign out     = main_d[p_depth-1];

`ifdef PIPESTAGE_COUNT_EN
  localparam int CW  = $clog2(2*p_depth+1);
  localparam int CAP = 2 * p_depth;

  logic          in_xfer;
  logic          out_xfer;
  logic [CW-1:0] cnt;

  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (in_xfer && !out_xfer) begin
      cnt <= cnt + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign o_count = cnt;

  a_full_not_ready : assert property (@(posedge i_clk) disable iff (i_rst)
    (o_count == CW'(CAP)) |-> !o_ready);
`endif

endmodule
